// File: rtl/hw_jpeg_pkg.sv
// Shared constants for the JPEG DC front end: quantiser steps, component
// encodings and the baseline DC Huffman tables.
package hw_jpeg_pkg;

  localparam int Q_LUM_DEF    = 16;
  localparam int Q_CHROMA_DEF = 17;

  typedef enum logic [1:0] {
    COMP_Y     = 2'd0,
    COMP_CB    = 2'd1,
    COMP_CR    = 2'd2,
    COMP_Y_ALT = 2'd3
  } comp_e;

  typedef struct packed {
    logic [10:0] code;
    logic [3:0]  len;
  } huff_t;

  function automatic huff_t dc_huff(input logic chroma, input logic [3:0] cat);
    huff_t h;
    h = '{11'h000, 4'd2};
    if (!chroma) begin
      case (cat)
        4'd1:    h = '{11'h002, 4'd3};
        4'd2:    h = '{11'h003, 4'd3};
        4'd3:    h = '{11'h004, 4'd3};
        4'd4:    h = '{11'h005, 4'd3};
        4'd5:    h = '{11'h006, 4'd3};
        4'd6:    h = '{11'h00E, 4'd4};
        4'd7:    h = '{11'h01E, 4'd5};
        4'd8:    h = '{11'h03E, 4'd6};
        4'd9:    h = '{11'h07E, 4'd7};
        4'd10:   h = '{11'h0FE, 4'd8};
        4'd11:   h = '{11'h1FE, 4'd9};
        default: h = '{11'h000, 4'd2};
      endcase
    end else begin
      case (cat)
        4'd1:    h = '{11'h001, 4'd2};
        4'd2:    h = '{11'h002, 4'd2};
        4'd3:    h = '{11'h006, 4'd3};
        4'd4:    h = '{11'h00E, 4'd4};
        4'd5:    h = '{11'h01E, 4'd5};
        4'd6:    h = '{11'h03E, 4'd6};
        4'd7:    h = '{11'h07E, 4'd7};
        4'd8:    h = '{11'h0FE, 4'd8};
        4'd9:    h = '{11'h1FE, 4'd9};
        4'd10:   h = '{11'h3FE, 4'd10};
        4'd11:   h = '{11'h7FE, 4'd11};
        default: h = '{11'h000, 4'd2};
      endcase
    end
    return h;
  endfunction

endpackage

// File: rtl/hw_jpeg_enc_rgb2ycbcr.sv
// Registered RGB to YCbCr conversion with fixed-point BT.601 weights;
// each component is saturated to 0..255.
module rgb_to_ycbcr (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] i_red,
  input  logic [7:0] i_green,
  input  logic [7:0] i_blue,
  output logic [7:0] o_y,
  output logic [7:0] o_cb,
  output logic [7:0] o_cr
);

  function automatic logic [7:0] sat_u8(input logic signed [17:0] v);
    if (v < 18'sd0)        return 8'd0;
    else if (v > 18'sd255) return 8'd255;
    else                   return v[7:0];
  endfunction

  logic signed [17:0] w_r, w_g, w_b;
  logic signed [17:0] w_y_acc, w_cb_acc, w_cr_acc;
  logic signed [17:0] w_y_s, w_cb_s, w_cr_s;

  assign w_r = $signed({10'd0, i_red});
  assign w_g = $signed({10'd0, i_green});
  assign w_b = $signed({10'd0, i_blue});

  assign w_y_acc  = 18'sd77 * w_r + 18'sd150 * w_g + 18'sd29 * w_b + 18'sd128;
  assign w_cb_acc = 18'sd128 * w_b - 18'sd43 * w_r - 18'sd85 * w_g + 18'sd128;
  assign w_cr_acc = 18'sd128 * w_r - 18'sd107 * w_g - 18'sd21 * w_b + 18'sd128;

  // Arithmetic shift keeps negative chroma sums flooring toward -inf
  assign w_y_s  = w_y_acc >>> 8;
  assign w_cb_s = (w_cb_acc >>> 8) + 18'sd128;
  assign w_cr_s = (w_cr_acc >>> 8) + 18'sd128;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      o_y  <= 8'd0;
      o_cb <= 8'd0;
      o_cr <= 8'd0;
    end else begin
      o_y  <= sat_u8(w_y_s);
      o_cb <= sat_u8(w_cb_s);
      o_cr <= sat_u8(w_cr_s);
    end
  end

endmodule

// File: rtl/hw_jpeg_enc.sv
// JPEG DC front end: buffers one 8x8 block of a colour component, quantises
// its DC term and emits the DPCM difference as a Huffman-coded DC symbol.
module hw_jpeg_enc
  import hw_jpeg_pkg::*;
#(
  parameter int Q_LUM    = Q_LUM_DEF,
  parameter int Q_CHROMA = Q_CHROMA_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         input_enable,
  input  logic         input_1pix_enable,
  input  logic [7:0]   Red,
  input  logic [7:0]   Green,
  input  logic [7:0]   Blue,
  input  logic [1:0]   comp_sel,
  input  logic         Huffman_start,
  output logic [511:0] pix_data,
  output logic         jpeg_out_enable,
  output logic [23:0]  jpeg_dc_out,
  output logic [4:0]   jpeg_dc_len,
  output logic [15:0]  jpeg_out,
  output logic [3:0]   jpeg_data_bits
);

  // Round half away from zero: sign(s) * floor((|s| + 4q) / 8q)
  function automatic logic signed [15:0] quant_dc(input logic signed [13:0] s, input int q);
    logic signed [15:0] se;
    logic [15:0]        mag;
    logic [31:0]        num;
    se  = 16'(s);
    mag = se[15] ? 16'(-se) : 16'(se);
    num = (32'(mag) + 32'(4 * q)) / 32'(8 * q);
    return se[15] ? -16'(num[15:0]) : 16'(num[15:0]);
  endfunction

  function automatic logic [3:0] dc_cat(input logic signed [15:0] d);
    logic [15:0] mag;
    logic [3:0]  c;
    mag = d[15] ? 16'(-d) : 16'(d);
    c   = 4'd0;
    for (int i = 0; i < 11; i++) if (mag[i]) c = 4'(i + 1);
    if (|mag[15:11]) c = 4'd11;
    return c;
  endfunction

  logic [7:0]         w_y, w_cb, w_cr, w_sample;
  logic signed [13:0] w_delta;
  logic signed [15:0] w_dc_lum, w_dc_chr, w_dc;
  logic               w_start_ok;
  logic [3:0]         w_cat;
  huff_t              w_huff;
  logic [15:0]        w_amp_src;
  logic [23:0]        w_mask, w_amp;

  logic               r_pix_vld_p0;
  logic [5:0]         r_ptr;
  logic               r_full;
  logic signed [13:0] r_sum;
  comp_e              r_comp;
  logic [511:0]       r_pix_data;
  logic signed [15:0] r_prev_dc [3];
  logic               r_vld_p1;
  logic signed [15:0] r_diff_p1;
  logic               r_chroma_p1;
  logic               r_out_en_p2;
  logic [23:0]        r_dc_out_p2;
  logic [4:0]         r_dc_len_p2;
  logic [15:0]        r_jpeg_out_p2;
  logic [3:0]         r_bits_p2;

  rgb_to_ycbcr u_csc (
    .clock   (clock),
    .reset   (reset),
    .i_red   (Red),
    .i_green (Green),
    .i_blue  (Blue),
    .o_y     (w_y),
    .o_cb    (w_cb),
    .o_cr    (w_cr)
  );

  always_comb begin
    case (r_comp)
      COMP_CB: w_sample = w_cb;
      COMP_CR: w_sample = w_cr;
      default: w_sample = w_y;
    endcase
  end

  assign w_delta = $signed({6'd0, w_sample}) - 14'sd128;

  // p0: block accumulation; a restart wins over a coincident pixel
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pix_vld_p0 <= 1'b0;
      r_ptr        <= 6'd0;
      r_full       <= 1'b0;
      r_sum        <= 14'sd0;
      r_comp       <= COMP_Y;
      r_pix_data   <= '0;
    end else begin
      r_pix_vld_p0 <= input_1pix_enable;
      if (input_enable) begin
        r_ptr  <= 6'd0;
        r_sum  <= 14'sd0;
        r_full <= 1'b0;
        r_comp <= (comp_sel == 2'd3) ? COMP_Y : comp_e'(comp_sel);
      end else if (r_pix_vld_p0 && !r_full) begin
        r_pix_data[{r_ptr, 3'b000} +: 8] <= w_sample;
        r_sum <= r_sum + w_delta;
        r_ptr <= r_ptr + 6'd1;
        if (r_ptr == 6'd63) r_full <= 1'b1;
      end
    end
  end

  assign w_dc_lum   = quant_dc(r_sum, Q_LUM);
  assign w_dc_chr   = quant_dc(r_sum, Q_CHROMA);
  assign w_dc       = (r_comp == COMP_Y) ? w_dc_lum : w_dc_chr;
  assign w_start_ok = Huffman_start && r_full && !r_vld_p1;

  // p1: quantised DC and DPCM difference against this component's history
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vld_p1    <= 1'b0;
      r_diff_p1   <= 16'sd0;
      r_chroma_p1 <= 1'b0;
      for (int i = 0; i < 3; i++) r_prev_dc[i] <= 16'sd0;
    end else begin
      r_vld_p1 <= w_start_ok;
      if (w_start_ok) begin
        r_diff_p1         <= w_dc - r_prev_dc[r_comp];
        r_chroma_p1       <= (r_comp != COMP_Y);
        r_prev_dc[r_comp] <= w_dc;
      end
    end
  end

  assign w_cat     = dc_cat(r_diff_p1);
  assign w_huff    = dc_huff(r_chroma_p1, w_cat);
  assign w_amp_src = r_diff_p1[15] ? 16'(r_diff_p1 - 16'sd1) : 16'(r_diff_p1);
  assign w_mask    = (24'd1 << w_cat) - 24'd1;
  assign w_amp     = {8'd0, w_amp_src} & w_mask;

  // p2: symbol assembly; outputs hold between encodes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_en_p2   <= 1'b0;
      r_dc_out_p2   <= 24'd0;
      r_dc_len_p2   <= 5'd0;
      r_jpeg_out_p2 <= 16'd0;
      r_bits_p2     <= 4'd0;
    end else begin
      r_out_en_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_dc_out_p2   <= (24'(w_huff.code) << w_cat) | w_amp;
        r_dc_len_p2   <= 5'(w_huff.len) + 5'(w_cat);
        r_jpeg_out_p2 <= r_diff_p1;
        r_bits_p2     <= w_cat;
      end
    end
  end

  assign pix_data        = r_pix_data;
  assign jpeg_out_enable = r_out_en_p2;
  assign jpeg_dc_out     = r_dc_out_p2;
  assign jpeg_dc_len     = r_dc_len_p2;
  assign jpeg_out        = r_jpeg_out_p2;
  assign jpeg_data_bits  = r_bits_p2;

endmodule

// File: tb/tb_hw_jpeg_enc.sv
// Randomised self-checking bench for hw_jpeg_enc against a block-level
// reference model (colour formulas, DC quantiser, DPCM and Huffman tables).
module tb_hw_jpeg_enc;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         input_enable = 1'b0;
  logic         input_1pix_enable = 1'b0;
  logic [7:0]   Red = 8'd0, Green = 8'd0, Blue = 8'd0;
  logic [1:0]   comp_sel = 2'd0;
  logic         Huffman_start = 1'b0;
  logic [511:0] pix_data;
  logic         jpeg_out_enable;
  logic [23:0]  jpeg_dc_out;
  logic [4:0]   jpeg_dc_len;
  logic [15:0]  jpeg_out;
  logic [3:0]   jpeg_data_bits;

  always #5 clock = ~clock;

  hw_jpeg_enc dut (
    .clock             (clock),
    .reset             (reset),
    .input_enable      (input_enable),
    .input_1pix_enable (input_1pix_enable),
    .Red               (Red),
    .Green             (Green),
    .Blue              (Blue),
    .comp_sel          (comp_sel),
    .Huffman_start     (Huffman_start),
    .pix_data          (pix_data),
    .jpeg_out_enable   (jpeg_out_enable),
    .jpeg_dc_out       (jpeg_dc_out),
    .jpeg_dc_len       (jpeg_dc_len),
    .jpeg_out          (jpeg_out),
    .jpeg_data_bits    (jpeg_data_bits)
  );

  string LUM_TAB[12] = '{"00", "010", "011", "100", "101", "110", "1110", "11110",
                         "111110", "1111110", "11111110", "111111110"};
  string CHR_TAB[12] = '{"00", "01", "10", "110", "1110", "11110", "111110", "1111110",
                         "11111110", "111111110", "1111111110", "11111111110"};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          m_ptr, m_sum, m_comp;
  bit          m_full;
  int          m_prev[3];
  int          m_buf[64];
  logic [23:0] e_dc_out;
  logic [4:0]  e_len;
  logic [15:0] e_out;
  logic [3:0]  e_bits;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  function automatic int conv(input int r, input int g, input int b, input int c);
    case (c)
      1:       return sat(((-43 * r - 85 * g + 128 * b + 128) >>> 8) + 128);
      2:       return sat(((128 * r - 107 * g - 21 * b + 128) >>> 8) + 128);
      default: return sat((77 * r + 150 * g + 29 * b + 128) >>> 8);
    endcase
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_sum = 0; m_comp = 0; m_full = 1'b0;
    for (int i = 0; i < 3; i++) m_prev[i] = 0;
    for (int i = 0; i < 64; i++) m_buf[i] = 0;
    e_dc_out = '0; e_len = '0; e_out = '0; e_bits = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic flush();
    tick();
    tick();
  endtask

  task automatic start_block(input int c);
    input_enable = 1'b1;
    comp_sel = 2'(c);
    tick();
    input_enable = 1'b0;
    m_ptr = 0; m_sum = 0; m_full = 1'b0;
    m_comp = (c == 3) ? 0 : c;
  endtask

  task automatic push(input int r, input int g, input int b);
    int s;
    Red = 8'(r); Green = 8'(g); Blue = 8'(b);
    input_1pix_enable = 1'b1;
    tick();
    input_1pix_enable = 1'b0;
    if (!m_full) begin
      s = conv(r, g, b, m_comp);
      m_buf[m_ptr] = s;
      m_sum += s - 128;
      m_ptr++;
      if (m_ptr == 64) m_full = 1'b1;
    end
  endtask

  // r < 0 selects a random pixel
  task automatic fill(input int n, input int r, input int g, input int b);
    for (int i = 0; i < n; i++) begin
      if (r < 0) push($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      else       push(r, g, b);
    end
  endtask

  task automatic chk_pix(input string tag);
    logic [511:0] e;
    for (int i = 0; i < 64; i++) e[8 * i +: 8] = 8'(m_buf[i]);
    chk(tag, pix_data, e);
  endtask

  task automatic encode(input string tag);
    bit    fire;
    int    q, a, dcv, diff, cat, code, clen;
    string s;
    fire = m_full;
    if (fire) begin
      q   = (m_comp == 0) ? 16 : 17;
      a   = (m_sum < 0) ? -m_sum : m_sum;
      dcv = (a + 4 * q) / (8 * q);
      if (m_sum < 0) dcv = -dcv;
      diff = dcv - m_prev[m_comp];
      m_prev[m_comp] = dcv;
      a   = (diff < 0) ? -diff : diff;
      cat = 0;
      while ((1 << cat) <= a) cat++;
      s    = (m_comp == 0) ? LUM_TAB[cat] : CHR_TAB[cat];
      clen = s.len();
      code = 0;
      for (int i = 0; i < clen; i++) code = code * 2 + ((s[i] == 8'h31) ? 1 : 0);
      e_dc_out = 24'((code << cat) | ((diff >= 0) ? diff : diff + (1 << cat) - 1));
      e_len    = 5'(clen + cat);
      e_out    = 16'(diff);
      e_bits   = 4'(cat);
    end
    Huffman_start = 1'b1;
    tick();
    Huffman_start = 1'b0;
    chk({tag, "/early"}, 512'(jpeg_out_enable), 512'(0));
    tick();
    chk({tag, "/pulse"}, 512'(jpeg_out_enable), 512'(fire));
    chk({tag, "/dc_out"}, 512'(jpeg_dc_out), 512'(e_dc_out));
    chk({tag, "/len"}, 512'(jpeg_dc_len), 512'(e_len));
    chk({tag, "/diff"}, 512'(jpeg_out), 512'(e_out));
    chk({tag, "/bits"}, 512'(jpeg_data_bits), 512'(e_bits));
    tick();
    chk({tag, "/pulse_end"}, 512'(jpeg_out_enable), 512'(0));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "/pix"}, pix_data, 512'(0));
    chk({tag, "/en"}, 512'(jpeg_out_enable), 512'(0));
    chk({tag, "/dc_out"}, 512'(jpeg_dc_out), 512'(0));
    chk({tag, "/len"}, 512'(jpeg_dc_len), 512'(0));
    chk({tag, "/diff"}, 512'(jpeg_out), 512'(0));
    chk({tag, "/bits"}, 512'(jpeg_data_bits), 512'(0));
  endtask

  typedef struct { int r; int g; int b; int c; int y; } conv_vec_t;
  conv_vec_t conv_vecs[7] = '{
    '{255, 255, 255, 0, 255}, '{255, 255, 255, 1, 128}, '{255, 255, 255, 2, 128},
    '{255, 0, 0, 0, 77}, '{255, 0, 0, 1, 85}, '{255, 0, 0, 2, 255}, '{0, 0, 255, 3, 29}};

  initial begin
    logic [511:0] snap;
    model_reset();
    repeat (3) tick();
    chk_zero_outputs("reset");
    reset = 1'b0;
    tick();

    // Colour conversion and its one-cycle latency
    start_block(0);
    push(255, 255, 255);
    chk("conv_latency/before", 512'(pix_data[7:0]), 512'(0));
    tick();
    chk("conv_latency/after", 512'(pix_data[7:0]), 512'(255));
    foreach (conv_vecs[k]) begin
      start_block(conv_vecs[k].c);
      push(conv_vecs[k].r, conv_vecs[k].g, conv_vecs[k].b);
      flush();
      chk($sformatf("conv%0d", k), 512'(pix_data[7:0]), 512'(conv_vecs[k].y));
    end

    // Directed DC sequence: gray, white, black on Y, then gray on Cb
    start_block(0); fill(64, 128, 128, 128); flush();
    encode("gray_y");
    chk("gray_y/const", {jpeg_out, jpeg_data_bits, jpeg_dc_out, jpeg_dc_len}, {16'h0, 4'd0, 24'h0, 5'd2});
    start_block(0); fill(64, 255, 255, 255); flush();
    encode("white_y");
    chk("white_y/const", {jpeg_out, jpeg_data_bits, jpeg_dc_out, jpeg_dc_len}, {16'h0040, 4'd7, 24'hF40, 5'd12});
    start_block(0); fill(64, 0, 0, 0); flush();
    encode("black_y");
    chk("black_y/const", {jpeg_out, jpeg_data_bits, jpeg_dc_out, jpeg_dc_len}, {16'hFF80, 4'd8, 24'h3E7F, 5'd14});
    start_block(1); fill(64, 128, 128, 128); flush();
    encode("gray_cb");
    chk("gray_cb/const", {jpeg_out, jpeg_data_bits, jpeg_dc_out, jpeg_dc_len}, {16'h0, 4'd0, 24'h0, 5'd2});
    encode("gray_cb_again");

    // Short block must not encode; completing it must
    start_block(0); fill(63, -1, 0, 0); flush();
    encode("short_block");
    fill(1, -1, 0, 0); flush();
    encode("completed_block");
    chk_pix("completed_pix");

    // Pixels past a full block are ignored
    snap = pix_data;
    push(17, 200, 3); flush();
    chk("pixel65", pix_data, snap);
    chk_pix("pixel65_model");

    // Mid-block restart discards the partial sum
    start_block(2); fill(30, 255, 255, 255); flush();
    start_block(2); fill(64, -1, 0, 0); flush();
    encode("restart_cr");
    chk_pix("restart_pix");

    // Asynchronous reset mid-block
    start_block(1); fill(20, -1, 0, 0);
    reset = 1'b1;
    #1;
    chk_zero_outputs("async_reset");
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    start_block(0); fill(64, 255, 255, 255); flush();
    encode("post_reset_white");

    // Random blocks across all component selects
    for (int it = 0; it < 10; it++) begin
      start_block($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        fill($urandom_range(1, 63), -1, 0, 0); flush();
        start_block($urandom_range(0, 3));
      end
      fill(64, -1, 0, 0); flush();
      encode($sformatf("rand%0d", it));
      chk_pix($sformatf("rand%0d/pix", it));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
